// File: rtl/param_pipe.sv
// Parameterisable pipeline: ready/valid elastic pipe with bubble collapse (ELASTIC=1)
// or fixed-delay shift pipe with a sticky overflow flag (ELASTIC=0).
module param_pipe #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int ELASTIC = 1,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             drop
);

  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] valid_next;
  logic [DEPTH-1:0] take;
  logic [WIDTH-1:0] data_reg [DEPTH];
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             drop_reg;
  logic             drop_next;

  // take[i]: stage i is empty or advancing, so it can load from its upstream neighbour.
  always_comb begin
    take = '1;
    if (ELASTIC != 0) begin
      take[DEPTH-1] = out_ready | ~valid_reg[DEPTH-1];
      for (int i = DEPTH - 2; i >= 0; i--) begin
        take[i] = ~valid_reg[i] | take[i+1];
      end
    end
  end

  assign in_ready = ~rstn | (take[0] & ~flush);

  always_comb begin
    valid_next = valid_reg;
    if (take[0]) begin
      valid_next[0] = in_valid & ~flush;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (take[i]) begin
        valid_next[i] = valid_reg[i-1];
      end
    end
    if (flush) begin
      valid_next = '0;
    end
  end

  always_comb begin
    count_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_next = count_next + CNT_W'(valid_next[i]);
    end
  end

  always_comb begin
    drop_next = 1'b0;
    if (ELASTIC == 0) begin
      drop_next = ~flush & (drop_reg | (valid_reg[DEPTH-1] & ~out_ready));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_reg <= '0;
      count_reg <= '0;
      drop_reg  <= 1'b0;
    end else begin
      valid_reg <= valid_next;
      count_reg <= count_next;
      drop_reg  <= drop_next;
    end
  end

  // Data only moves alongside a valid word; empty stages keep stale contents.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_reg[i] <= '0;
      end
    end else begin
      if (take[0] && in_valid && !flush) begin
        data_reg[0] <= in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (take[i] && valid_reg[i-1]) begin
          data_reg[i] <= data_reg[i-1];
        end
      end
    end
  end

  assign out_valid = valid_reg[DEPTH-1];
  assign out_data  = data_reg[DEPTH-1];
  assign count     = count_reg;
  assign drop      = drop_reg;

endmodule
